// File: rtl/l2_flatten.sv
// rtl/l2_flatten.sv - interleaves the two layer-1 banks into the flattened layer-2 vector (optional checksum: L2_FLATTEN_CHK_EN)
module l2_flatten #(
    parameter int NUM_ELEM = 1024,
    parameter int AW       = 12,
    parameter int DW       = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
`ifdef L2_FLATTEN_CHK_EN
    output logic [2:0]    csel,
    output logic [23:0]   chk_sum
`else
    output logic [2:0]    csel
`endif
);

    localparam int IW = $clog2(NUM_ELEM);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD0  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] WR0  = 3'd3;
    localparam logic [2:0] WR1  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [2:0] SEL_IDLE = 3'b000;
    localparam logic [2:0] SEL_K0   = 3'b011;
    localparam logic [2:0] SEL_K1   = 3'b100;
    localparam logic [2:0] SEL_L2   = 3'b101;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEM - 1);

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;

    // Next element index; only consumed on the WR1 -> RD0 transition.
    always_comb begin
        idx_next = idx + 1'b1;
    end

    // Sequencer: every output is registered and set on entry to the state it belongs to,
    // so the bus signals line up exactly with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= SEL_IDLE;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RD0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        crd      <= 1'b1;
                        csel     <= SEL_K0;
                        caddr_rd <= '0;
                    end
                end
                RD0: begin
                    state    <= RD1;
                    crd      <= 1'b1;
                    csel     <= SEL_K1;
                    caddr_rd <= {{(AW-IW){1'b0}}, idx};
                end
                RD1: begin
                    // Kernel-0 word returns now; it is the first write of the pair.
                    state    <= WR0;
                    crd      <= 1'b0;
                    cwr      <= 1'b1;
                    csel     <= SEL_L2;
                    caddr_wr <= {{(AW-IW-1){1'b0}}, idx, 1'b0};
                    cdata_wr <= cdata_rd;
                end
                WR0: begin
                    // Kernel-1 word returns now; it goes to the odd address.
                    state    <= WR1;
                    cwr      <= 1'b1;
                    csel     <= SEL_L2;
                    caddr_wr <= {{(AW-IW-1){1'b0}}, idx, 1'b1};
                    cdata_wr <= cdata_rd;
                end
                WR1: begin
                    cwr <= 1'b0;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        csel  <= SEL_IDLE;
                    end else begin
                        state    <= RD0;
                        idx      <= idx_next;
                        crd      <= 1'b1;
                        csel     <= SEL_K0;
                        caddr_rd <= {{(AW-IW){1'b0}}, idx_next};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    crd   <= 1'b0;
                    cwr   <= 1'b0;
                    csel  <= SEL_IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    crd   <= 1'b0;
                    cwr   <= 1'b0;
                    csel  <= SEL_IDLE;
                end
            endcase
        end
    end

`ifdef L2_FLATTEN_CHK_EN
    // Running checksum of every word written, accumulated as it is loaded into cdata_wr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_sum <= '0;
        end else if (state == IDLE && start) begin
            chk_sum <= '0;
        end else if (state == RD1 || state == WR0) begin
            chk_sum <= chk_sum + 24'(cdata_rd);
        end
    end
`endif

endmodule

// File: tb/tb_l2_flatten.sv
// tb/tb_l2_flatten.sv - randomized self-checking bench for l2_flatten with a cycle-level reference model
module tb_l2_flatten;

    localparam int N   = 1024;
    localparam int AW  = 12;
    localparam int DW  = 20;
    localparam int RUN = 4 * N + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd, cdata_wr;
    logic [2:0]    csel;
`ifdef L2_FLATTEN_CHK_EN
    logic [23:0]   chk_sum;
`endif

    logic [DW-1:0] k0 [N];
    logic [DW-1:0] k1 [N];
    logic [DW-1:0] l2m [2*N];
    int            l2_gen [2*N];
    logic [AW-1:0] last_wr;
    logic [23:0]   exp_sum;
    int            gen = 0;
    int            t = 0;
    int            checks = 0;
    int            failures = 0;

    l2_flatten #(.NUM_ELEM(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
`ifdef L2_FLATTEN_CHK_EN
        .csel     (csel),
        .chk_sum  (chk_sum)
`else
        .csel     (csel)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result memory: registered read, write into the L2 bank tagged with the run generation.
    always @(posedge clk) begin
        if (crd) begin
            case (csel)
                3'd3:    cdata_rd <= k0[caddr_rd[9:0]];
                3'd4:    cdata_rd <= k1[caddr_rd[9:0]];
                default: cdata_rd <= '0;
            endcase
        end
        if (cwr && csel == 3'd5) begin
            l2m[caddr_wr[10:0]]    <= cdata_wr;
            l2_gen[caddr_wr[10:0]] <= gen;
            last_wr                <= caddr_wr;
        end
    end

    // Reference timeline: t counts cycles since an accepted start (0 = idle).
    always @(posedge clk or negedge reset) begin
        if (!reset)         t <= 0;
        else if (t == 0)    t <= start ? 1 : 0;
        else if (t == RUN)  t <= 0;
        else                t <= t + 1;
    end

    // Per-cycle comparison of all outputs against the timeline.
    always @(negedge clk) begin
        int e, ph;
        logic [5:0] exp_ctrl;
        e = (t - 1) / 4;
        ph = (t - 1) % 4;
        if (t >= 1 && t < RUN) begin
            case (ph)
                0: exp_ctrl = {1'b0, 1'b1, 1'b0, 3'd3};
                1: exp_ctrl = {1'b0, 1'b1, 1'b0, 3'd4};
                default: exp_ctrl = {1'b0, 1'b0, 1'b1, 3'd5};
            endcase
            check("busy_run", 64'(busy), 64'd1);
            if (ph < 2) check("caddr_rd", 64'(caddr_rd), 64'(e));
            if (ph == 2) begin
                check("caddr_wr_even", 64'(caddr_wr), 64'(2 * e));
                check("cdata_wr_k0", 64'(cdata_wr), 64'(k0[e]));
            end
            if (ph == 3) begin
                check("caddr_wr_odd", 64'(caddr_wr), 64'(2 * e + 1));
                check("cdata_wr_k1", 64'(cdata_wr), 64'(k1[e]));
            end
        end else if (t == RUN) begin
            exp_ctrl = {1'b1, 1'b0, 1'b0, 3'd0};
        end else begin
            exp_ctrl = '0;
            check("busy_idle", 64'(busy), 64'd0);
        end
        check("ctrl_done_crd_cwr_csel", 64'({done, crd, cwr, csel}), 64'(exp_ctrl));
        if (!reset) check("reset_regs", 64'({caddr_rd, caddr_wr, cdata_wr}), 64'd0);
    end

    task automatic fill(input int mode);
        gen++;
        exp_sum = '0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin k0[i] = DW'(i); k1[i] = 20'hFFFFF - DW'(i); end
                1: begin k0[i] = DW'($urandom); k1[i] = DW'($urandom); end
                2: begin k0[i] = 20'h00001; k1[i] = 20'h00001; end
                default: begin k0[i] = 20'hFFFFF; k1[i] = 20'hFFFFF; end
            endcase
            exp_sum = exp_sum + 24'(k0[i]) + 24'(k1[i]);
        end
    endtask

    // Ends at the negedge of the first cycle after start was sampled.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done (bounded), optionally poking start mid-run; ends at the done negedge.
    task automatic wait_run(input bit inject);
        int cyc;
        int bad;
        cyc = 1;
        while (!done && cyc < RUN + 200) begin
            @(negedge clk);
            cyc++;
            if (!done)
                start = inject && (cyc == 100 || cyc == 2000 ||
                        (cyc < RUN - 10 && $urandom_range(0, 300) == 0));
        end
        start = 1'b0;
        check("done_latency", 64'(cyc), 64'(RUN));
        bad = 0;
        for (int i = 0; i < 2 * N; i++) begin
            if (l2_gen[i] != gen) bad++;
            else if (l2m[i] !== ((i % 2 == 0) ? k0[i/2] : k1[i/2])) bad++;
        end
        check("writeback_bad_words", 64'(bad), 64'd0);
`ifdef L2_FLATTEN_CHK_EN
        check("chk_sum_model", 64'(chk_sum), 64'(exp_sum));
`endif
    endtask

    initial begin
        for (int i = 0; i < 2 * N; i++) l2_gen[i] = 0;
        for (int i = 0; i < N; i++) begin k0[i] = '0; k1[i] = '0; end
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_outputs", 64'({busy, done, crd, cwr, csel}), 64'd0);

        // Ramp data with stray starts during the run.
        fill(0);
        pulse_start();
        wait_run(1'b1);
        check("ramp_l2_0", 64'(l2m[0]), 64'h0);
        check("ramp_l2_1", 64'(l2m[1]), 64'hFFFFF);
        check("ramp_l2_2046", 64'(l2m[2046]), 64'd1023);
        check("ramp_l2_2047", 64'(l2m[2047]), 64'hFFC00);
        check("last_write_addr", 64'(last_wr), 64'd2047);

        // Start held across the done cycle (ignored) and the following idle cycle (accepted).
        fill(1);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_run(1'b1);

        // Reset at element 500 aborts the run.
        fill(1);
        pulse_start();
        repeat (2000) @(negedge clk);
        #1 reset = 1'b0;
        #1 check("async_reset_outputs",
                 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        fill(1);
        pulse_start();
        wait_run(1'b0);

        fill(2);
        pulse_start();
        wait_run(1'b0);
`ifdef L2_FLATTEN_CHK_EN
        check("chk_sum_ones", 64'(chk_sum), 64'd2048);
`endif
        fill(3);
        pulse_start();
        wait_run(1'b0);
`ifdef L2_FLATTEN_CHK_EN
        check("chk_sum_all_f", 64'(chk_sum), 64'hFFF800);
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
